instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Front-end consumer of the fetch PC. Owns the fetch address, issues word requests on the
//  instruction-memory req/gnt/rvalid interface, buffers returned words and hands {instr, pc}
//  to decode over a valid/ready handshake. Supports pipelined requests and redirects
//  (branch/jump/trap), discarding stale in-flight responses.
// PARAMETERS
//  XLEN        32             address/data width
//  RESET_PC    32'h4000_0000  first fetch address after reset
//  BUF_DEPTH   2              response buffer entries (power of 2, >=2); also the credit limit
// PORTS
//  clk_i          in   1     clock
//  rst_ni         in   1     asynchronous, active-low reset
//  redirect_i     in   1     flush and restart fetch at redirect_pc_i
//  redirect_pc_i  in   XLEN  new fetch address (word aligned)
//  imem_req_o     out  1     request valid
//  imem_addr_o    out  XLEN  request word address
//  imem_gnt_i     in   1     request accepted this cycle (req & gnt = handshake)
//  imem_rvalid_i  in   1     response valid; responses return in request order, >=1 cycle after gnt
//  imem_rdata_i   in   XLEN  instruction word
//  instr_valid_o  out  1     instruction available to decode
//  instr_ready_i  in   1     decode accepts (valid & ready = pop)
//  instr_o        out  XLEN  instruction word
//  instr_pc_o     out  XLEN  PC of instr_o
// BEHAVIOUR
//  Reset: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=RESET_PC;
//   buffer empty, outstanding=0, discard=0, state RUN. imem_req_o rises first cycle after reset.
//  Credit: issue allowed when outstanding + occupancy < BUF_DEPTH; outstanding +1 on req&gnt,
//   -1 on rvalid. Buffer can never overflow; rvalid while full is an assertion failure.
//  Request rule: once imem_req_o=1, req and imem_addr_o are held stable until gnt, even across
//   redirect. On req&gnt, fetch address += 4 (wraps modulo 2^XLEN); req may stay high
//   back-to-back (one grant per cycle max) while credit allows.
//  FSM: RUN - normal issue. HOLD - redirect arrived while req&!gnt: keep old addr/req, latch
//   redirect_pc in pending_pc_q; on gnt that request is counted in discard, go RUN with
//   imem_addr_o=pending_pc_q. A further redirect in HOLD overwrites pending_pc_q.
//  Redirect (RUN, no pending ungranted req, or req&gnt same cycle): buffer flushed same cycle,
//   discard <= outstanding (+1 if gnt this cycle, -1 if rvalid this cycle), next
//   imem_addr_o=redirect_pc_i, deliver_pc <= redirect_pc_i. instr_valid_o=0 next cycle.
//  Response: rvalid with discard>0 -> dropped, discard -1; else word pushed into buffer.
//   Push to output is registered: earliest instr_valid_o is the cycle after rvalid.
//  Output: instr_valid_o = buffer non-empty; instr_o = head word; instr_pc_o = deliver_pc,
//   which advances +4 on each pop (sequential fetch => no per-entry PC storage).
//  Simultaneous: pop+push same cycle on full buffer allowed; redirect+pop same cycle: handshake
//   completes for decode, buffer still flushed; redirect beats push (word discarded).
//  Alignment: addr[1:0] always 0; misaligned redirect_pc_i is forced aligned (bits[1:0]
//   ignored) - misalignment traps are raised upstream.
//  Reset mid-operation clears all state; memory is reset on the same rst_ni.
// STRUCTURE
//  Shared package riscv_pkg: ILEN, PC_STEP (=4), fetch FSM enum fetch_state_e {RUN, HOLD}.
//  Sub-module fetch_buffer: synchronous FIFO (push/pop/flush, full/empty, count) instantiated
//   once; counters, FSM and address logic stay in instr_fetch_unit.
// TESTING
//  1 Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> addrs 4000_0000,..04,..08;
//    instr_pc_o follows same sequence, one instruction per cycle sustained.
//  2 ready=0 for 10 cycles -> exactly BUF_DEPTH requests granted then req=0; no word lost;
//    on ready=1 words pop in order with pcs 4000_0000, 4000_0004.
//  3 Two granted requests in flight, redirect to 4000_0100 -> both responses dropped,
//    first delivered instr_pc_o=4000_0100 carrying rdata for addr 4000_0100.
//  4 gnt held 0 with req high at 4000_0008, redirect to 4000_0200 -> addr stays 4000_0008
//    until gnt, its response discarded, next addr 4000_0200.
//  5 Redirect, pop and rvalid in same cycle -> decode handshake completes, rvalid word
//    discarded, buffer empty next cycle, discard count correct (no later stale delivery).
//  6 Assert rst_ni low with 2 outstanding and full buffer -> all outputs at reset values
//    immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// No logic; imported by the fetch unit and its response buffer.
package riscv_pkg;

    localparam int unsigned ILEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Response buffer for fetched words: head visible one cycle after push, flush clears it.
// Push while full is only taken with a same-cycle pop; otherwise it is refused.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = ILEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word requests, buffers responses, delivers {instr, pc}.
// Word reaches decode the cycle after rvalid; issue is credit-limited to BUF_DEPTH in use.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h4000_0000,
    parameter int unsigned      BUF_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [XLEN-1:0]  imem_rdata_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [XLEN-1:0]  instr_o,
    output logic [XLEN-1:0]  instr_pc_o
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic [XLEN-1:0] deliver_pc_q, deliver_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     in_use;
    logic            run_q;
    logic            held_q;
    logic            credit_ok;
    logic            req;
    logic            fire;
    logic            pop;
    logic            drop;
    logic            push;
    logic            buf_full;
    logic            buf_empty;
    logic [XLEN-1:0] redirect_pc_al;

    assign redirect_pc_al = {redirect_pc_i[XLEN-1:2], 2'b00};

    // A same-cycle pop frees a slot, which keeps issue at one word per cycle.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign credit_ok = in_use < ((CW+1)'(BUF_DEPTH) + (CW+1)'(pop));

    assign req  = run_q & (held_q | credit_ok);
    assign fire = req & imem_gnt_i;
    assign pop  = instr_valid_o & instr_ready_i;
    assign drop = imem_rvalid_i & (discard_q != '0);
    assign push = imem_rvalid_i & (discard_q == '0) & ~redirect_i;

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_addr_q;
    assign instr_valid_o = ~buf_empty;
    assign instr_pc_o    = deliver_pc_q;

    fetch_buffer #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push),
        .push_dat (imem_rdata_i),
        .pop      (pop),
        .flush    (redirect_i),
        .head_dat (instr_o),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        pending_pc_d  = pending_pc_q;
        deliver_pc_d  = deliver_pc_q;
        outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid_i);
        discard_d     = discard_q - CW'(drop);

        if (pop) begin
            deliver_pc_d = deliver_pc_q + XLEN'(PC_STEP);
        end
        if (fire) begin
            fetch_addr_d = fetch_addr_q + XLEN'(PC_STEP);
        end
        // The request held across a redirect is stale once granted.
        if (state_q == HOLD && fire) begin
            discard_d    = discard_d + CW'(1);
            fetch_addr_d = pending_pc_q;
            state_d      = RUN;
        end
        if (redirect_i) begin
            discard_d    = outstanding_d;
            deliver_pc_d = redirect_pc_al;
            if (req && !imem_gnt_i) begin
                state_d      = HOLD;
                pending_pc_d = redirect_pc_al;
            end else begin
                state_d      = RUN;
                fetch_addr_d = redirect_pc_al;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            fetch_addr_q  <= {RESET_PC[XLEN-1:2], 2'b00};
            pending_pc_q  <= {RESET_PC[XLEN-1:2], 2'b00};
            deliver_pc_q  <= {RESET_PC[XLEN-1:2], 2'b00};
            outstanding_q <= '0;
            discard_q     <= '0;
            run_q         <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            pending_pc_q  <= pending_pc_d;
            deliver_pc_q  <= deliver_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            run_q         <= 1'b1;
            held_q        <= req & ~imem_gnt_i;
        end
    end

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_rvalid_i && buf_full && !pop));

    a_no_spurious_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_rvalid_i && outstanding_q == '0));

endmodule
